// File: rtl/barrett_dispatch_if.sv
// Signal bundle between barrett_dispatch, its word producer, the Barrett core
// and the result consumer.
interface barrett_dispatch_if #(
   parameter int DATA_WIDTH = 32,
   parameter int Q_WIDTH    = 23
);
   // in_* / out_*: a beat moves on the rising edge where valid && ready are both high;
   // valid and data hold steady until that edge, and ready never waits on valid.
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  core_start;
   logic [DATA_WIDTH-1:0] core_data;
   logic [Q_WIDTH-1:0]    core_q;
   logic                  core_done;
   logic [Q_WIDTH-1:0]    core_result;
   logic                  out_valid;
   logic                  out_ready;
   logic [Q_WIDTH-1:0]    out_data;

   modport master (
      input  in_valid, in_data, core_done, core_result, out_ready,
      output in_ready, core_start, core_data, core_q, out_valid, out_data
   );

   modport slave (
      output in_valid, in_data, core_done, core_result, out_ready,
      input  in_ready, core_start, core_data, core_q, out_valid, out_data
   );
endinterface

// File: rtl/barrett_dispatch.sv
// Issue stage for the Barrett core: input FIFO, one-at-a-time start/done sequencing,
// result register, modulus register and hung-core timeout.
module barrett_dispatch #(
   parameter int DATA_WIDTH = 32,
   parameter int Q_WIDTH    = 23,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic               clk,
   input  logic               rst,
   barrett_dispatch_if.master bus,
   input  logic               q_load,
   input  logic [Q_WIDTH-1:0] q_in,
   output logic               busy,
   output logic               timeout_err,
   output logic               cfg_err,
   output logic [1:0]         state_dbg
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   PTR_ONE  = 1;
   localparam logic [CW-1:0] CNT_ONE  = 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]           wr_ptr_q, rd_ptr_q;
   logic [DATA_WIDTH-1:0] core_data_q;
   logic [Q_WIDTH-1:0]    core_q_q, out_data_q;
   logic                  out_valid_q, timeout_err_q, cfg_err_q;
   logic [CW-1:0]         wait_cnt_q;

   logic fifo_empty, fifo_full, push, pop, issue_go, drain;
   logic start, capture, abort;

   // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push       = bus.in_valid && !fifo_full;
   assign drain      = out_valid_q && bus.out_ready;
   assign issue_go   = !fifo_empty && (!out_valid_q || bus.out_ready);
   assign pop        = (state_q == S_IDLE) && issue_go;
   assign busy       = (state_q != S_IDLE) || !fifo_empty || out_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (issue_go) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (bus.core_done || (wait_cnt_q == CNT_LAST)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A done arriving on the last permitted WAIT cycle still wins over the abort.
   always_comb begin
      start   = 1'b0;
      capture = 1'b0;
      abort   = 1'b0;
      case (state_q)
         S_ISSUE: start = 1'b1;
         S_WAIT: begin
            capture = bus.core_done;
            abort   = !bus.core_done && (wait_cnt_q == CNT_LAST);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         core_data_q   <= '0;
         core_q_q      <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         cfg_err_q     <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop) begin
            rd_ptr_q    <= rd_ptr_q + PTR_ONE;
            core_data_q <= mem_q[rd_ptr_q[AW-1:0]];
         end
         if (start)                 wait_cnt_q <= '0;
         else if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + CNT_ONE;
         if (capture) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.core_result;
         end else if (drain) begin
            out_valid_q <= 1'b0;
         end
         if (abort) timeout_err_q <= 1'b1;
         // The modulus only changes when nothing is queued, in flight or unread.
         if (q_load) begin
            if (busy) begin
               cfg_err_q <= 1'b1;
            end else begin
               core_q_q  <= q_in;
               cfg_err_q <= 1'b0;
            end
         end
      end
   end

   assign bus.in_ready   = !fifo_full;
   assign bus.core_start = start;
   assign bus.core_data  = core_data_q;
   assign bus.core_q     = core_q_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign timeout_err    = timeout_err_q;
   assign cfg_err        = cfg_err_q;
   assign state_dbg      = state_q;
endmodule
